mem_data_unit: RTL and testbench
================================

MEM_DATA_UNIT -- requirements
Module: mem_data_unit

Interface
REQ-001 Parameter DEPTH_BYTES, default 256, memory size in bytes; power of two, >= 8.
REQ-002 Parameter LOCAL_AW, default $clog2(DEPTH_BYTES), byte-index width; derived, not overridden.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset; starts the clear sequence.
REQ-005 i_mem_addr  in  32  byte address of the load/store.
REQ-006 i_mem_data_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 i_mem_write_enable  in  1  store request for the current cycle.
REQ-008 i_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
REQ-009 i_mem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-010 i_clear  in  1  single-cycle request to re-zero the whole memory.
REQ-011 i_du_mem_addr  in  32  debug-unit byte address, word read.
REQ-012 o_mem_data_out  out  32  extended load data.
REQ-013 o_du_mem_data  out  32  debug word.
REQ-014 o_misaligned  out  1  current access is misaligned or has a reserved size.
REQ-015 o_busy  out  1  clear sequence in progress; the pipeline stalls on it.

Function
REQ-016 Storage SHALL be DEPTH_BYTES bytes, little-endian; byte index = addr[LOCAL_AW-1:0]; upper address bits ignored (wrap-around).
REQ-017 Misaligned SHALL be: half with addr[0]=1; word with addr[1:0]!=0; size 11 always. o_misaligned is combinational from i_mem_addr/i_mem_size, independent of o_busy.
REQ-018 Loads SHALL be combinational (zero latency): byte/half taken from the addressed bytes, extended per i_mem_unsigned; word unextended.
REQ-019 o_mem_data_out SHALL be 0 when o_misaligned=1 or o_busy=1.
REQ-020 Store SHALL commit at the rising edge only when i_mem_write_enable=1, o_misaligned=0, o_busy=0 and i_clear=0; only the 1, 2 or 4 addressed bytes are written.
REQ-021 Misaligned or reserved-size stores SHALL be dropped; no byte changes.
REQ-022 Debug read SHALL be combinational at word address i_du_mem_addr[LOCAL_AW-1:2]; low two bits are ignored. It is valid during clear and returns current contents.
REQ-023 A load at the same address as a same-cycle store SHALL return the old data; new data is visible the cycle after the edge.
REQ-024 Clear FSM states: IDLE, CLEAR; word counter clr_idx, width LOCAL_AW-2.
REQ-025 IDLE -> CLEAR on i_clear=1; clr_idx <= 0.
REQ-026 In CLEAR, each edge SHALL zero word clr_idx and increment it; after word DEPTH_BYTES/4-1 is zeroed, go to IDLE. Clear takes DEPTH_BYTES/4 cycles.
REQ-027 o_busy = (state == CLEAR); registered state, no combinational path from i_clear.
REQ-028 i_clear while in CLEAR SHALL be ignored; the sequence does not restart.
REQ-029 If i_clear and a store occur in the same IDLE cycle, the clear wins and the store is dropped.

Reset
REQ-030 i_reset=1 at an edge SHALL force state=CLEAR and clr_idx=0, overriding i_clear and stores. Reset asserted mid-clear restarts at word 0.
REQ-031 After the reset edge: o_busy=1, o_mem_data_out=0; o_misaligned and o_du_mem_data follow inputs/contents.
REQ-032 Memory contents SHALL NOT be bulk-cleared in one cycle; zeroing happens only through the clear sequence. All memory is zero once o_busy first falls after reset.

Structure
REQ-033 Package mem_data_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the clear-state enum.
REQ-034 Sub-module mem_data_clr SHALL contain the clear FSM and counter, outputting busy, clear-write-enable and word index. Storage, alignment logic and extension stay in mem_data_unit.

Verification
REQ-035 Reset for 1 cycle, then idle -> o_busy high exactly 64 cycles (DEPTH_BYTES=256), then debug reads of all 64 words return 0.
REQ-036 SW 0x8899AABB @0x10; then LB @0x13 signed -> 0xFFFFFF88; LBU @0x13 -> 0x00000088; LH @0x12 signed -> 0xFFFF8899; LHU @0x10 -> 0x0000AABB.
REQ-037 SB 0x12 @0x21 after SW 0 @0x20 -> word @0x20 = 0x00001200; SH 0x3456 @0x22 -> word @0x20 = 0x34561200.
REQ-038 SW @0x11 and SH @0x05 -> o_misaligned=1, contents unchanged, o_mem_data_out=0; size 11 @0x00 -> o_misaligned=1.
REQ-039 Set address 0x104 with DEPTH_BYTES=256 -> same byte as 0x04. i_clear in IDLE plus a same-cycle SW -> store dropped, 64-cycle clear. i_reset at clear cycle 30 -> clear restarts; o_busy then stays high 64 more cycles.
REQ-040 Store attempted while o_busy=1 -> dropped. Load then -> 0. Debug read during clear -> uncleared words retain prior data.

Source files
------------

// File: rtl/mem_data_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_pkg
//  Purpose  : Shared encodings for the data memory unit: access-size codes,
//             clear-sequencer state values and the alignment rule.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_data_pkg;

    // Access size encoding on i_mem_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Clear sequencer states
    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // An access is misaligned when it does not sit on its natural boundary.
    // The reserved size code is reported the same way so that it is never
    // committed or returned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b1;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_clr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_clr
//  Purpose  : Clear sequencer. Walks every word of the data memory once,
//             one word per clock, asserting a write strobe for the word
//             currently being zeroed.
//  Ports    : i_clk      - clock
//             i_reset    - synchronous active-high reset, starts a clear
//             i_clear    - single-cycle clear request (honoured in IDLE)
//             o_busy     - clear sequence in progress
//             o_clr_we   - zero the word at o_clr_idx on this edge
//             o_clr_idx  - word index being zeroed
//  Revision : 1.0 - initial release
// ============================================================================
module mem_data_clr
    import mem_data_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int WORD_AW     = $clog2(DEPTH_BYTES) - 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    output logic               o_busy,
    output logic               o_clr_we,
    output logic [WORD_AW-1:0] o_clr_idx
);

    localparam logic [0:0]         c_ST_IDLE  = CLR_IDLE;
    localparam logic [0:0]         c_ST_CLEAR = CLR_CLEAR;
    localparam logic [WORD_AW-1:0] c_LAST_IDX = WORD_AW'(DEPTH_BYTES / 4 - 1);

    logic [0:0]         r_state;
    logic [WORD_AW-1:0] r_idx;

    // Reset always (re)starts the walk from word 0, even mid-clear, so the
    // memory is guaranteed zero when busy first drops after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_ST_CLEAR;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= c_ST_CLEAR;
                        r_idx   <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    // Further clear requests are ignored; the walk finishes.
                    r_idx <= r_idx + WORD_AW'(1);
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (r_state == c_ST_CLEAR);
    assign o_clr_we  = (r_state == c_ST_CLEAR);
    assign o_clr_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/mem_data_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_unit
//  Purpose  : Byte-addressed little-endian data memory with zero-latency
//             loads (sign/zero extended), byte/half/word stores, alignment
//             detection, a debug word-read port and a sequenced clear.
//  Ports    : i_clk, i_reset        - clock, synchronous active-high reset
//             i_mem_addr            - load/store byte address
//             i_mem_data_in         - right-aligned store data
//             i_mem_write_enable    - store request this cycle
//             i_mem_size            - 00 byte, 01 half, 10 word, 11 reserved
//             i_mem_unsigned        - load zero-extend (1) / sign-extend (0)
//             i_clear               - request to re-zero the memory
//             i_du_mem_addr         - debug word address
//             o_mem_data_out        - extended load data
//             o_du_mem_data         - debug read word
//             o_misaligned          - misaligned or reserved-size access
//             o_busy                - clear sequence running
//  Revision : 1.0 - initial release
// ============================================================================
module mem_data_unit
    import mem_data_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int LOCAL_AW    = $clog2(DEPTH_BYTES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_data_in,
    input  logic        i_mem_write_enable,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic        i_clear,
    input  logic [31:0] i_du_mem_addr,
    output logic [31:0] o_mem_data_out,
    output logic [31:0] o_du_mem_data,
    output logic        o_misaligned,
    output logic        o_busy
);

    localparam int c_WORD_AW = LOCAL_AW - 2;

    // Byte storage; never reset in bulk, only zeroed by the clear walk.
    logic [7:0] r_mem [DEPTH_BYTES];

    logic                 w_busy;
    logic                 w_clr_we;
    logic [c_WORD_AW-1:0] w_clr_idx;
    logic                 w_misaligned;
    logic [c_WORD_AW-1:0] w_word_idx;
    logic [c_WORD_AW-1:0] w_du_idx;
    logic [31:0]          w_rd_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;
    logic                 w_store;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    mem_data_clr #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .WORD_AW     (c_WORD_AW)
    ) u_clr (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_clear),
        .o_busy    (w_busy),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

    // ------------------------------------------------------------------
    // Addressing: upper address bits are ignored, so accesses wrap.
    // ------------------------------------------------------------------
    assign w_misaligned = is_misaligned(i_mem_size, i_mem_addr[1:0]);
    assign w_word_idx   = i_mem_addr[LOCAL_AW-1:2];
    assign w_du_idx     = i_du_mem_addr[LOCAL_AW-1:2];

    assign w_rd_word = {r_mem[{w_word_idx, 2'd3}], r_mem[{w_word_idx, 2'd2}],
                        r_mem[{w_word_idx, 2'd1}], r_mem[{w_word_idx, 2'd0}]};

    assign o_du_mem_data = {r_mem[{w_du_idx, 2'd3}], r_mem[{w_du_idx, 2'd2}],
                            r_mem[{w_du_idx, 2'd1}], r_mem[{w_du_idx, 2'd0}]};

    // ------------------------------------------------------------------
    // Load path: lane select then extend. Aligned halves only ever sit in
    // the low or high half of the containing word.
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        w_load = 32'h0000_0000;

        case (i_mem_addr[1:0])
            2'd0:    w_byte = w_rd_word[7:0];
            2'd1:    w_byte = w_rd_word[15:8];
            2'd2:    w_byte = w_rd_word[23:16];
            default: w_byte = w_rd_word[31:24];
        endcase
        w_half = i_mem_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

        case (i_mem_size)
            SZ_BYTE: w_load = i_mem_unsigned ? {24'h000000, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load = i_mem_unsigned ? {16'h0000, w_half}
                                             : {{16{w_half[15]}}, w_half};
            SZ_WORD: w_load = w_rd_word;
            default: w_load = 32'h0000_0000;
        endcase

        if (w_misaligned || w_busy) begin
            w_load = 32'h0000_0000;
        end
    end

    assign o_mem_data_out = w_load;
    assign o_misaligned   = w_misaligned;
    assign o_busy         = w_busy;

    // ------------------------------------------------------------------
    // Store path: replicate the right-aligned data across the lanes and
    // let the byte enables pick which lanes land in memory.
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_mem_data_in;
        case (i_mem_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << i_mem_addr[1:0];
                w_wdata = {4{i_mem_data_in[7:0]}};
            end
            SZ_HALF: begin
                w_be    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_mem_data_in[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = i_mem_data_in;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = i_mem_data_in;
            end
        endcase
    end

    // A clear request or reset on the same edge takes priority over a store.
    assign w_store = i_mem_write_enable & ~w_misaligned & ~w_busy
                   & ~i_clear & ~i_reset;

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++) begin
            if (w_clr_we) begin
                r_mem[{w_clr_idx, 2'(l)}] <= 8'h00;
            end else if (w_store && w_be[l]) begin
                r_mem[{w_word_idx, 2'(l)}] <= w_wdata[8*l +: 8];
            end
        end
    end

    // Address bits outside the memory window are intentionally ignored.
    assign w_unused = ^{i_mem_addr[31:LOCAL_AW], i_du_mem_addr[31:LOCAL_AW],
                        i_du_mem_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_data_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_data_unit
//  Purpose  : Self-checking bench for mem_data_unit (DEPTH_BYTES = 256).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_data_unit;
    import mem_data_pkg::*;

    localparam int c_DEPTH  = 256;
    localparam int c_NWORDS = c_DEPTH / 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        clear;
    logic [31:0] du_mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] du_mem_data;
    logic        misaligned;
    logic        busy;

    mem_data_unit #(.DEPTH_BYTES(c_DEPTH)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_mem_addr         (mem_addr),
        .i_mem_data_in      (mem_data_in),
        .i_mem_write_enable (mem_write_enable),
        .i_mem_size         (mem_size),
        .i_mem_unsigned     (mem_unsigned),
        .i_clear            (clear),
        .i_du_mem_addr      (du_mem_addr),
        .o_mem_data_out     (mem_data_out),
        .o_du_mem_data      (du_mem_data),
        .o_misaligned       (misaligned),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_out;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [7:0]  model [c_DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic [31:0] addr,
                                input logic [31:0] data, input logic we,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] exp_out, input logic exp_mis);
        vec_t v;
        v.name = name; v.addr = addr; v.data = data; v.we = we;
        v.size = size; v.uns = uns; v.exp_out = exp_out; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]};
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [1:0] size);
        int a;
        a = int'(addr[7:0]);
        if (size == SZ_BYTE) begin
            model[a] = data[7:0];
        end else if (size == SZ_HALF) begin
            model[a]   = data[7:0];
            model[a+1] = data[15:8];
        end else if (size == SZ_WORD) begin
            model[a]   = data[7:0];
            model[a+1] = data[15:8];
            model[a+2] = data[23:16];
            model[a+3] = data[31:24];
        end
    endfunction

    function automatic void model_zero();
        for (int b = 0; b < c_DEPTH; b++) model[b] = 8'h00;
    endfunction

    task automatic set_bus(input logic [31:0] addr, input logic [31:0] data,
                           input logic we, input logic [1:0] size,
                           input logic uns, input logic clr);
        mem_addr         = addr;
        mem_data_in      = data;
        mem_write_enable = we;
        mem_size         = size;
        mem_unsigned     = uns;
        clear            = clr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles while busy stays high, bounded so a stuck FSM still ends.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            next_cycle();
            cnt++;
        end
    endtask

    // Debug-reads every word (with junk in ignored address bits) against the model.
    task automatic check_all_words(input string tag);
        for (int w = 0; w < c_NWORDS; w++) begin
            du_mem_addr = 32'(w * 4) | 32'(w % 4) | (32'h0000_0100 * 32'(w % 2));
            #1;
            chk($sformatf("%s_w%0d", tag, w), du_mem_data, model_word(w));
        end
    endtask

    initial begin
        int          cnt;
        logic [31:0] exp;

        set_bus(32'h0, 32'h0, 1'b0, SZ_WORD, 1'b0, 1'b0);
        du_mem_addr = 32'h0;
        reset       = 1'b1;
        model_zero();

        // ---------------- reset and initial clear ----------------
        next_cycle();
        reset = 1'b0;
        mem_addr = 32'h10;
        #1;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_load_zero", mem_data_out, 32'h0);
        count_busy(cnt);
        chk("reset_clear_len", 32'(cnt), 32'd64);
        check_all_words("init_zero");

        // ---------------- table-driven loads/stores ----------------
        add("sw_10",     32'h10,  32'h8899AABB, 1, SZ_WORD, 0, 32'h0,        0);
        add("lb_13",     32'h13,  32'h0,        0, SZ_BYTE, 0, 32'hFFFFFF88, 0);
        add("lbu_13",    32'h13,  32'h0,        0, SZ_BYTE, 1, 32'h00000088, 0);
        add("lh_12",     32'h12,  32'h0,        0, SZ_HALF, 0, 32'hFFFF8899, 0);
        add("lhu_10",    32'h10,  32'h0,        0, SZ_HALF, 1, 32'h0000AABB, 0);
        add("lh_10",     32'h10,  32'h0,        0, SZ_HALF, 0, 32'hFFFFAABB, 0);
        add("lw_10",     32'h10,  32'h0,        0, SZ_WORD, 0, 32'h8899AABB, 0);
        add("lbu_11",    32'h11,  32'h0,        0, SZ_BYTE, 1, 32'h000000AA, 0);
        add("sw_20",     32'h20,  32'h0,        1, SZ_WORD, 0, 32'h0,        0);
        add("sb_21",     32'h21,  32'hABCDEF12, 1, SZ_BYTE, 1, 32'h0,        0);
        add("lw_20a",    32'h20,  32'h0,        0, SZ_WORD, 0, 32'h00001200, 0);
        add("sh_22",     32'h22,  32'h99993456, 1, SZ_HALF, 1, 32'h0,        0);
        add("lw_20b",    32'h20,  32'h0,        0, SZ_WORD, 0, 32'h34561200, 0);
        add("sw_11_mis", 32'h11,  32'hDEADBEEF, 1, SZ_WORD, 0, 32'h0,        1);
        add("sh_05_mis", 32'h05,  32'h0000BEEF, 1, SZ_HALF, 0, 32'h0,        1);
        add("rsv_00",    32'h00,  32'h0,        0, SZ_RSVD, 0, 32'h0,        1);
        add("rsv_00_st", 32'h00,  32'h11111111, 1, SZ_RSVD, 0, 32'h0,        1);
        add("lw_10_keep",32'h10,  32'h0,        0, SZ_WORD, 0, 32'h8899AABB, 0);
        add("lw_04_zero",32'h04,  32'h0,        0, SZ_WORD, 0, 32'h0,        0);
        add("sw_104",    32'h104, 32'hCAFEF00D, 1, SZ_WORD, 0, 32'h0,        0);
        add("lw_04",     32'h04,  32'h0,        0, SZ_WORD, 0, 32'hCAFEF00D, 0);
        add("lbu_104",   32'h104, 32'h0,        0, SZ_BYTE, 1, 32'h0000000D, 0);
        add("sw_30",     32'h30,  32'h11223344, 1, SZ_WORD, 0, 32'h0,        0);
        add("sw_30_old", 32'h30,  32'h55667788, 1, SZ_WORD, 0, 32'h11223344, 0);
        add("lw_30",     32'h30,  32'h0,        0, SZ_WORD, 0, 32'h55667788, 0);
        add("lh_32",     32'h32,  32'h0,        0, SZ_HALF, 0, 32'h00005566, 0);
        add("lb_31",     32'h31,  32'h0,        0, SZ_BYTE, 0, 32'h00000077, 0);
        add("lb_30",     32'h30,  32'h0,        0, SZ_BYTE, 0, 32'hFFFFFF88, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_bus(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].size, vecs[i].uns, 1'b0);
            exp_q.push_back(vecs[i].exp_out);
            #3;
            exp = exp_q.pop_front();
            chk(vecs[i].name, mem_data_out, exp);
            chk({vecs[i].name, "_mis"}, 32'(misaligned), 32'(vecs[i].exp_mis));
            if (vecs[i].we && !vecs[i].exp_mis)
                model_store(vecs[i].addr, vecs[i].data, vecs[i].size);
            next_cycle();
        end
        set_bus(32'h0, 32'h0, 1'b0, SZ_WORD, 1'b0, 1'b0);
        check_all_words("after_table");

        // ---------------- clear with same-cycle store ----------------
        set_bus(32'h40, 32'h55555555, 1'b1, SZ_WORD, 1'b0, 1'b1);
        #3;
        chk("clr_busy_not_comb", 32'(busy), 32'd0);
        next_cycle();
        set_bus(32'h0, 32'h0, 1'b0, SZ_WORD, 1'b0, 1'b0);
        cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt == 5) begin
                du_mem_addr = 32'h10;
                mem_addr    = 32'h30;
                #1;
                chk("du_cleared_w4", du_mem_data, 32'h0);
                du_mem_addr = 32'h30;
                #1;
                chk("du_retained_w12", du_mem_data, model_word(12));
                chk("load_during_busy", mem_data_out, 32'h0);
                set_bus(32'h0, 32'h77777777, 1'b1, SZ_WORD, 1'b0, 1'b0);
            end else if (cnt == 6) begin
                set_bus(32'h0, 32'h0, 1'b0, SZ_WORD, 1'b0, 1'b1);
            end else if (cnt == 7) begin
                clear = 1'b0;
            end
            next_cycle();
            cnt++;
        end
        chk("clear_len_idle", 32'(cnt), 32'd64);
        model_zero();
        check_all_words("after_clear");

        // ---------------- reset in the middle of a clear ----------------
        set_bus(32'hA0, 32'hA5A5A5A5, 1'b1, SZ_WORD, 1'b0, 1'b0);
        model_store(32'hA0, 32'hA5A5A5A5, SZ_WORD);
        next_cycle();
        set_bus(32'h0, 32'h0, 1'b0, SZ_WORD, 1'b0, 1'b1);
        next_cycle();
        clear = 1'b0;
        cnt = 0;
        while (busy && cnt < 30) begin
            next_cycle();
            cnt++;
        end
        chk("midclear_still_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        mem_addr    = 32'hA0;
        du_mem_addr = 32'hA0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        chk("rst_mid_load_zero", mem_data_out, 32'h0);
        chk("rst_mid_du_w40", du_mem_data, 32'hA5A5A5A5);
        count_busy(cnt);
        chk("rst_mid_clear_len", 32'(cnt), 32'd64);
        model_zero();
        check_all_words("after_rst_clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
